// File: rtl/interco_pkg.sv
// Shared interconnect definitions: default sizes and the initiator-ID decode.
package interco_pkg;

  localparam int unsigned N_INIT_DEF          = 4;
  localparam int unsigned ID_WIDTH_DEF        = 2;
  localparam int unsigned DATA_WIDTH_DEF      = 32;
  localparam int unsigned MAX_OUTSTANDING_DEF = 4;

  // One-hot decode of an initiator ID, evaluated one branch at a time so the
  // caller can size the vector to its own N_INIT. An ID outside the valid
  // range decodes to no branch at all.
  function automatic logic id_onehot_bit(
    input int unsigned id,
    input int unsigned branch_idx,
    input int unsigned n_init
  );
    return (id == branch_idx) && (id < n_init);
  endfunction

endpackage

// File: rtl/id_fifo.sv
// In-order ID tracker FIFO: array storage with a registered read port, a
// wrap-bit pointer pair and an occupancy counter that drives full/empty.
module id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      r_count;

  // Storage write and registered read; no reset so the array maps onto RAM.
  // The caller never pops the slot being pushed (it only pops when non-empty
  // and never pushes when full), so no read/write collision handling is needed.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    if (i_pop)  r_rdata <= r_mem[r_rptr[AW-1:0]];
  end

  // Pointers advance independently; the counter is the sole full/empty source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + ONE;
      if (i_pop)  r_rptr <= r_rptr + ONE;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + ONE;
        2'b01:   r_count <= r_count - ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_rdata;
  assign o_count = r_count;

endmodule

// File: rtl/resp_fanout_tracker.sv
// Per-bank response distributor: remembers who was granted, in order, and
// steers each bank response back to that initiator as a one-hot valid.
module resp_fanout_tracker import interco_pkg::*; #(
  parameter int unsigned N_INIT          = N_INIT_DEF,
  parameter int unsigned ID_WIDTH        = ID_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               data_req_i,
  input  logic [ID_WIDTH-1:0]                data_ID_i,
  input  logic                               data_gnt_i,
  output logic                               data_gnt_o,
  output logic                               data_req_o,
  input  logic                               data_r_valid_i,
  input  logic [DATA_WIDTH-1:0]              data_r_rdata_i,
  output logic [N_INIT-1:0]                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0]              data_r_rdata_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               error_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(MAX_OUTSTANDING);

  logic [CW-1:0]         w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_orphan;
  logic                  w_bad_id;
  logic [ID_WIDTH-1:0]   w_pop_id;
  logic                  r_pop_q;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_error;

  // Masking uses the registered count, so a pop while full does not reopen
  // the grant until the following cycle.
  assign w_full     = (w_count == FULL_COUNT);
  assign w_empty    = (w_count == '0);
  assign data_gnt_o = data_gnt_i & ~w_full;
  assign data_req_o = data_req_i & ~w_full;
  assign w_push     = data_req_i & data_gnt_o;
  assign w_pop      = data_r_valid_i & ~w_empty;
  assign w_orphan   = data_r_valid_i & w_empty;

  // Out-of-range IDs only exist when N_INIT does not fill the ID space.
  generate
    if (N_INIT < (1 << ID_WIDTH)) begin : g_id_check
      assign w_bad_id = w_push & (32'(data_ID_i) >= 32'(N_INIT));
    end else begin : g_no_id_check
      assign w_bad_id = 1'b0;
    end
  endgenerate

  id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_WIDTH)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (data_ID_i),
    .i_pop   (w_pop),
    .o_rdata (w_pop_id),
    .o_count (w_count)
  );

  // Response register: flags a pop for one cycle, captures its data, and
  // accumulates the sticky protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pop_q <= 1'b0;
      r_rdata <= '0;
      r_error <= 1'b0;
    end else begin
      r_pop_q <= w_pop;
      if (w_pop) r_rdata <= data_r_rdata_i;
      r_error <= r_error | w_orphan | w_bad_id;
    end
  end

  // The popped ID is already registered by the FIFO read port, so decoding it
  // here keeps the one-cycle latency with only register-driven outputs.
  generate
    for (genvar gi = 0; gi < N_INIT; gi++) begin : g_valid
      assign data_r_valid_o[gi] = r_pop_q & id_onehot_bit(32'(w_pop_id), gi, N_INIT);
    end
  endgenerate

  assign data_r_rdata_o = r_rdata;
  assign outstanding_o  = w_count;
  assign error_o        = r_error;

endmodule

// File: tb/tb_resp_fanout_tracker.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed expectations and a random phase.
module tb_resp_fanout_tracker;

  localparam int N_INIT     = 4;
  localparam int ID_WIDTH   = 2;
  localparam int DATA_WIDTH = 32;
  localparam int MAXO       = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  data_req_i;
  logic [ID_WIDTH-1:0]   data_ID_i;
  logic                  data_gnt_i;
  logic                  data_gnt_o;
  logic                  data_req_o;
  logic                  data_r_valid_i;
  logic [DATA_WIDTH-1:0] data_r_rdata_i;
  logic [N_INIT-1:0]     data_r_valid_o;
  logic [DATA_WIDTH-1:0] data_r_rdata_o;
  logic [2:0]            outstanding_o;
  logic                  error_o;

  always #5 clk = ~clk;

  resp_fanout_tracker #(
    .N_INIT          (N_INIT),
    .ID_WIDTH        (ID_WIDTH),
    .DATA_WIDTH      (DATA_WIDTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_req_i     (data_req_i),
    .data_ID_i      (data_ID_i),
    .data_gnt_i     (data_gnt_i),
    .data_gnt_o     (data_gnt_o),
    .data_req_o     (data_req_o),
    .data_r_valid_i (data_r_valid_i),
    .data_r_rdata_i (data_r_rdata_i),
    .data_r_valid_o (data_r_valid_o),
    .data_r_rdata_o (data_r_rdata_o),
    .outstanding_o  (outstanding_o),
    .error_o        (error_o)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of granted IDs, plus the expected response outputs.
  int unsigned           mq[$];
  logic [N_INIT-1:0]     m_valid;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_err;
  bit                    m_push;
  int unsigned           m_id;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_valid = '0;
      m_rdata = '0;
      m_err   = 1'b0;
    end else begin
      m_push  = data_req_i && data_gnt_i && (mq.size() != MAXO);
      m_valid = '0;
      if (data_r_valid_i) begin
        if (mq.size() == 0) begin
          m_err = 1'b1;
        end else begin
          m_id = mq.pop_front();
          if (m_id < N_INIT) m_valid[m_id] = 1'b1;
          m_rdata = data_r_rdata_i;
        end
      end
      if (m_push) begin
        mq.push_back(int'(data_ID_i));
        if (int'(data_ID_i) >= N_INIT) m_err = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("valid",       data_r_valid_o, m_valid);
      check("rdata",       data_r_rdata_o, m_rdata);
      check("outstanding", outstanding_o,  mq.size());
      check("error",       error_o,        m_err);
      check("gnt_o",       data_gnt_o,     data_gnt_i && (mq.size() != MAXO));
      check("req_o",       data_req_o,     data_req_i && (mq.size() != MAXO));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_req_i     = 1'b0;
    data_gnt_i     = 1'b0;
    data_r_valid_i = 1'b0;
  endtask

  // Return every outstanding response; bounded by the FIFO depth.
  task automatic drain();
    for (int k = 0; k < MAXO + 1; k++) begin
      if (mq.size() > 0) begin
        data_r_valid_i = 1'b1;
        data_r_rdata_i = $urandom;
        step();
      end
    end
    data_r_valid_i = 1'b0;
  endtask

  int unsigned           t2_ids[4]  = '{3, 0, 1, 3};
  logic [DATA_WIDTH-1:0] t2_data[4] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
  logic [N_INIT-1:0]     t2_exp[4]  = '{4'b1000, 4'b0001, 4'b0010, 4'b1000};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    data_ID_i      = '0;
    data_r_rdata_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", data_r_valid_o, 0);
    check("reset_rdata", data_r_rdata_o, 0);
    check("reset_occ",   outstanding_o,  0);
    check("reset_err",   error_o,        0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Single request, response three cycles later
    data_req_i = 1'b1; data_gnt_i = 1'b1; data_ID_i = 2'd2;
    step();
    idle();
    check("t1_occ1", outstanding_o, 1);
    step(); step();
    data_r_valid_i = 1'b1; data_r_rdata_i = 32'hDEADBEEF;
    step();
    data_r_valid_i = 1'b0;
    check("t1_valid", data_r_valid_o, 4'b0100);
    check("t1_rdata", data_r_rdata_o, 32'hDEADBEEF);
    check("t1_occ0",  outstanding_o,  0);
    step();
    check("t1_valid_clear", data_r_valid_o, 0);
    check("t1_rdata_hold",  data_r_rdata_o, 32'hDEADBEEF);

    // Back-to-back requests, then back-to-back responses
    data_req_i = 1'b1; data_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_ID_i = ID_WIDTH'(t2_ids[i]);
      step();
    end
    idle();
    check("t2_occ4", outstanding_o, 4);
    for (int i = 0; i < 4; i++) begin
      data_r_valid_i = 1'b1;
      data_r_rdata_i = t2_data[i];
      step();
      check("t2_valid", data_r_valid_o, t2_exp[i]);
      check("t2_rdata", data_r_rdata_o, t2_data[i]);
    end
    data_r_valid_i = 1'b0;
    check("t2_occ0", outstanding_o, 0);
    step();

    // Full stall and release one cycle after a pop
    data_req_i = 1'b1; data_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_ID_i = ID_WIDTH'($urandom_range(0, N_INIT - 1));
      step();
    end
    check("t3_occ_full", outstanding_o, 4);
    check("t3_gnt_masked", data_gnt_o, 0);
    check("t3_req_masked", data_req_o, 0);
    data_r_valid_i = 1'b1; data_r_rdata_i = 32'h1234_5678;
    #1;
    check("t3_gnt_pop_same_cycle", data_gnt_o, 0);
    step();
    data_r_valid_i = 1'b0;
    check("t3_occ3", outstanding_o, 3);
    check("t3_gnt_released", data_gnt_o, 1);
    step();
    idle();
    check("t3_occ_refill", outstanding_o, 4);
    drain();
    step();

    // Streaming at occupancy 2 with latency 2; wraps the pointers several times
    data_req_i = 1'b1; data_gnt_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      data_ID_i = ID_WIDTH'($urandom_range(0, N_INIT - 1));
      step();
    end
    for (int i = 0; i < 12; i++) begin
      data_ID_i      = ID_WIDTH'($urandom_range(0, N_INIT - 1));
      data_r_valid_i = 1'b1;
      data_r_rdata_i = $urandom;
      step();
      check("t4_occ_const", outstanding_o, 2);
    end
    idle();
    drain();
    step();

    // Random traffic; responses only while something is outstanding
    for (int c = 0; c < 3000; c++) begin
      data_req_i     = ($urandom % 2) != 0;
      data_gnt_i     = ($urandom % 4) != 0;
      data_ID_i      = ID_WIDTH'($urandom_range(0, N_INIT - 1));
      data_r_valid_i = (mq.size() > 0) && (($urandom % 3) != 0);
      data_r_rdata_i = $urandom;
      step();
    end
    idle();
    drain();
    step();

    // Orphan response
    check("t5_pre_err", error_o, 0);
    data_r_valid_i = 1'b1; data_r_rdata_i = 32'hBAD0_0001;
    step();
    data_r_valid_i = 1'b0;
    check("t5_err", error_o, 1);
    check("t5_valid", data_r_valid_o, 0);
    check("t5_occ", outstanding_o, 0);
    step(); step();
    check("t5_err_sticky", error_o, 1);

    // Clear the sticky error, then reset asynchronously with 3 outstanding
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    step();
    check("t6_err_cleared", error_o, 0);
    data_req_i = 1'b1; data_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_ID_i = ID_WIDTH'(i + 1);
      step();
    end
    data_ID_i = 2'd0;
    data_r_valid_i = 1'b1; data_r_rdata_i = 32'h0F0F_0F0F;
    step();
    idle();
    check("t6_occ3", outstanding_o, 3);
    check("t6_valid_live", data_r_valid_o, 4'b0010);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", data_r_valid_o, 0);
    check("t6_rst_rdata", data_r_rdata_o, 0);
    check("t6_rst_occ",   outstanding_o,  0);
    check("t6_rst_err",   error_o,        0);
    @(posedge clk);
    #1 rst = 1'b0;
    data_r_valid_i = 1'b1; data_r_rdata_i = 32'h5A5A_5A5A;
    step();
    data_r_valid_i = 1'b0;
    check("t6_stale_err",   error_o,        1);
    check("t6_stale_valid", data_r_valid_o, 0);
    check("t6_stale_occ",   outstanding_o,  0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
